// File: rtl/key_pulse_gen.sv
// Debounced push-button front end: 2-FF synchronizer plus five-state FSM issuing a press strobe,
// a long-press strobe and a debounced level. Press strobe follows a stable press by DEB_CYCLES+2 edges.
module key_pulse_gen #(
    parameter int DEB_CYCLES  = 16,
    parameter int LONG_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pulse,
    output logic long_pulse,
    output logic pb_level
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        PRESSED = 3'd2,
        HELD    = 3'd3,
        REL     = 3'd4
    } state_t;

    localparam logic [15:0] DEB_MAX  = 16'(DEB_CYCLES);
    localparam logic [15:0] LONG_MAX = 16'(LONG_CYCLES);

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    logic [15:0] long_cnt_q, long_cnt_d;
    logic        pulse_q, pulse_d;
    logic        long_pulse_q, long_pulse_d;
    logic        pb_level_q, pb_level_d;
    logic        pb_sync;

    assign pb_sync = sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= 16'd0;
            long_cnt_q   <= 16'd0;
            pulse_q      <= 1'b0;
            long_pulse_q <= 1'b0;
            pb_level_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= pb_in;
            sync2_q      <= sync1_q;
            deb_cnt_q    <= deb_cnt_d;
            long_cnt_q   <= long_cnt_d;
            pulse_q      <= pulse_d;
            long_pulse_q <= long_pulse_d;
            pb_level_q   <= pb_level_d;
        end
    end

    // deb_cnt serves both press and release debounce; long_cnt freezes at LONG_MAX once fired.
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        long_cnt_d = long_cnt_q;
        case (state_q)
            IDLE: begin
                deb_cnt_d = 16'd0;
                if (pb_sync) begin
                    state_d   = ARM;
                    deb_cnt_d = 16'd1;
                end
            end
            ARM: begin
                if (!pb_sync) begin
                    state_d   = IDLE;
                    deb_cnt_d = 16'd0;
                end else if (deb_cnt_q + 16'd1 == DEB_MAX) begin
                    state_d    = PRESSED;
                    deb_cnt_d  = DEB_MAX;
                    long_cnt_d = 16'd0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 16'd1;
                end
            end
            PRESSED: begin
                if (!pb_sync) begin
                    state_d   = REL;
                    deb_cnt_d = 16'd1;
                end else if (long_cnt_q + 16'd1 == LONG_MAX) begin
                    state_d    = HELD;
                    long_cnt_d = LONG_MAX;
                end else begin
                    long_cnt_d = long_cnt_q + 16'd1;
                end
            end
            HELD: begin
                if (!pb_sync) begin
                    state_d   = REL;
                    deb_cnt_d = 16'd1;
                end
            end
            REL: begin
                if (pb_sync) begin
                    // Resuming counts this edge so a glitch delays the long strobe by its own length.
                    if (long_cnt_q == LONG_MAX) begin
                        state_d = HELD;
                    end else if (long_cnt_q + 16'd1 == LONG_MAX) begin
                        state_d    = HELD;
                        long_cnt_d = LONG_MAX;
                    end else begin
                        state_d    = PRESSED;
                        long_cnt_d = long_cnt_q + 16'd1;
                    end
                end else if (deb_cnt_q + 16'd1 == DEB_MAX) begin
                    state_d   = IDLE;
                    deb_cnt_d = 16'd0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                deb_cnt_d  = 16'd0;
                long_cnt_d = 16'd0;
            end
        endcase
    end

    always_comb begin
        pulse_d      = (state_q == ARM) && (state_d == PRESSED);
        long_pulse_d = (state_d == HELD) && (long_cnt_q != LONG_MAX);
        pb_level_d   = pb_level_q;
        if (pulse_d) begin
            pb_level_d = 1'b1;
        end else if ((state_q == REL) && (state_d == IDLE)) begin
            pb_level_d = 1'b0;
        end
    end

    assign pulse      = pulse_q;
    assign long_pulse = long_pulse_q;
    assign pb_level   = pb_level_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen: default instance plus a DEB_CYCLES=2 / LONG_CYCLES=1 corner instance.
module tb_key_pulse_gen;

    logic clk = 1'b0;
    logic rst;
    logic pb_in;
    logic pulse, long_pulse, pb_level;
    logic pulse2, long_pulse2, pb_level2;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    key_pulse_gen dut (
        .clk        (clk),
        .rst        (rst),
        .pb_in      (pb_in),
        .pulse      (pulse),
        .long_pulse (long_pulse),
        .pb_level   (pb_level)
    );

    key_pulse_gen #(.DEB_CYCLES(2), .LONG_CYCLES(1)) dut_c (
        .clk        (clk),
        .rst        (rst),
        .pb_in      (pb_in),
        .pulse      (pulse2),
        .long_pulse (long_pulse2),
        .pb_level   (pb_level2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        pb_in = 1'b0;
        rst   = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
        tick;
    endtask

    // Outputs are packed as {pulse, long_pulse, pb_level}.
    task automatic test_reset;
        logic [2:0] obs, exp;
        rst   = 1'b1;
        pb_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            obs = {pulse, long_pulse, pb_level};
            n_cmp++;
            if (obs !== 3'b000) begin
                n_err++;
                $display("FAIL reset_hold cycle %0d: got %b expected 000", i, obs);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            exp = {i == 18, 1'b0, i >= 18};
            obs = {pulse, long_pulse, pb_level};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_release edge %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_clean_press;
        logic [2:0] obs, exp;
        apply_reset;
        for (int i = 1; i <= 70; i++) begin
            pb_in = (i <= 40);
            tick;
            exp = {i == 18, 1'b0, (i >= 18) && (i < 58)};
            obs = {pulse, long_pulse, pb_level};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL clean_press edge %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_bounce;
        logic [2:0] obs, exp;
        apply_reset;
        for (int i = 1; i <= 60; i++) begin
            pb_in = (i > 30) ? 1'b1 : ((((i - 1) / 3) % 2) == 0);
            tick;
            exp = {i == 48, 1'b0, i >= 48};
            obs = {pulse, long_pulse, pb_level};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL bounce edge %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_long_press;
        logic [2:0] obs, exp;
        apply_reset;
        for (int i = 1; i <= 130; i++) begin
            pb_in = (i <= 100);
            tick;
            exp = {i == 18, i == 82, (i >= 18) && (i < 118)};
            obs = {pulse, long_pulse, pb_level};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL long_press edge %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_release_glitch;
        logic [2:0] obs, exp;
        apply_reset;
        for (int i = 1; i <= 100; i++) begin
            pb_in = !((i >= 31) && (i <= 35));
            tick;
            exp = {i == 18, i == 87, i >= 18};
            obs = {pulse, long_pulse, pb_level};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL release_glitch edge %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [2:0] obs, exp;
        apply_reset;
        for (int i = 1; i <= 24; i++) begin
            pb_in = 1'b1;
            tick;
            exp = {i == 18, 1'b0, i >= 18};
            obs = {pulse, long_pulse, pb_level};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_mid_pre edge %0d: got %b expected %b", i, obs, exp);
            end
        end
        rst = 1'b1;
        #1;
        obs = {pulse, long_pulse, pb_level};
        n_cmp++;
        if (obs !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_async: got %b expected 000", obs);
        end
        for (int i = 25; i <= 29; i++) begin
            tick;
            obs = {pulse, long_pulse, pb_level};
            n_cmp++;
            if (obs !== 3'b000) begin
                n_err++;
                $display("FAIL reset_mid_hold edge %0d: got %b expected 000", i, obs);
            end
        end
        rst = 1'b0;
        for (int i = 30; i <= 60; i++) begin
            tick;
            exp = {i == 47, 1'b0, i >= 47};
            obs = {pulse, long_pulse, pb_level};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_mid_post edge %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_param_corner;
        logic [2:0] obs, exp;
        apply_reset;
        for (int i = 1; i <= 20; i++) begin
            pb_in = (i <= 10);
            tick;
            exp = {i == 4, i == 5, (i >= 4) && (i < 14)};
            obs = {pulse2, long_pulse2, pb_level2};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL param_corner edge %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        pb_in = 1'b0;
        test_reset;
        test_clean_press;
        test_bounce;
        test_long_press;
        test_release_glitch;
        test_reset_mid;
        test_param_corner;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
